toggle_monitor: RTL and testbench

- Receiving end of the clock_gen/stimulus toggle interface. clock_gen drives a signal that toggles every half-period; this block watches that signal and checks it.
- Samples the toggling signal in the system clock domain, measures each half-period in clock cycles and compares it against an expected value.
- Reports lock, per-edge errors and loss of activity (stall).
- Used on-chip as a self-check for generated clocks and strobes.

---
 rtl/toggle_monitor.sv | 171 +++++++++++++++++
 tb/tb_toggle_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_monitor.sv
// toggle_monitor
// Watches a signal that is supposed to toggle every EXP_HALF clock cycles,
// measures every half-period and reports lock, per-edge errors and stalls.
//
// Ports:
//   clock        system clock, rising-edge active
//   reset        synchronous active-high reset
//   sig_in       monitored toggling signal (asynchronous to clock)
//   half_period  last measured half-period in clock cycles
//   period_valid one-cycle pulse when half_period updates
//   locked       high while the signal stays within tolerance
//   err          one-cycle pulse on an out-of-tolerance edge or a stall
//   err_count    saturating count of err pulses
//   stalled      high from a stall until the next detected edge
module toggle_monitor #(
    parameter int CNT_W    = 16,
    parameter int EXP_HALF = 10,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count,
    output logic             stalled
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  EXP_C     = CNT_W'(EXP_HALF);
    localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state_reg;
    logic              s1_reg, s2_reg, s3_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [GOOD_W-1:0] good_cnt_reg;
    logic [CNT_W-1:0]  half_period_reg;
    logic              period_valid_reg;
    logic              locked_reg;
    logic              err_reg;
    logic [7:0]        err_count_reg;
    logic              stalled_reg;

    logic              edge_evt;
    logic [CNT_W-1:0]  dev;
    logic              in_tol;
    logic              timeout_hit;
    logic              err_next;

    // Both polarities of the synchronized signal count as an edge.
    assign edge_evt = s2_reg ^ s3_reg;

    always_comb begin
        // Absolute deviation computed without wrap-around.
        dev         = (cnt_reg >= EXP_C) ? (cnt_reg - EXP_C) : (EXP_C - cnt_reg);
        in_tol      = (dev <= TOL_C);
        timeout_hit = (cnt_reg == TIMEOUT_C);
        err_next    = 1'b0;
        if (state_reg != IDLE) begin
            // An edge always takes priority over a coinciding timeout.
            err_next = edge_evt ? !in_tol : timeout_hit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            s1_reg           <= 1'b0;
            s2_reg           <= 1'b0;
            s3_reg           <= 1'b0;
            cnt_reg          <= '0;
            good_cnt_reg     <= '0;
            half_period_reg  <= '0;
            period_valid_reg <= 1'b0;
            locked_reg       <= 1'b0;
            err_reg          <= 1'b0;
            err_count_reg    <= 8'd0;
            stalled_reg      <= 1'b0;
        end else begin
            s1_reg <= sig_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;

            if (edge_evt) begin
                cnt_reg <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            period_valid_reg <= 1'b0;
            err_reg          <= err_next;
            if (err_next && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end

            if (edge_evt) begin
                stalled_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    // First edge only starts the measurement window.
                    if (edge_evt) begin
                        state_reg <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_evt) begin
                        half_period_reg  <= cnt_reg;
                        period_valid_reg <= 1'b1;
                        if (in_tol) begin
                            good_cnt_reg <= good_cnt_reg + 1'b1;
                            if ((good_cnt_reg + 1'b1) == LOCK_C) begin
                                state_reg  <= LOCKED;
                                locked_reg <= 1'b1;
                            end
                        end else begin
                            good_cnt_reg <= '0;
                        end
                    end else if (timeout_hit) begin
                        stalled_reg  <= 1'b1;
                        locked_reg   <= 1'b0;
                        good_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end
                end
                LOCKED: begin
                    if (edge_evt) begin
                        half_period_reg  <= cnt_reg;
                        period_valid_reg <= 1'b1;
                        if (!in_tol) begin
                            locked_reg   <= 1'b0;
                            good_cnt_reg <= '0;
                            state_reg    <= MEASURE;
                        end
                    end else if (timeout_hit) begin
                        stalled_reg  <= 1'b1;
                        locked_reg   <= 1'b0;
                        good_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign half_period  = half_period_reg;
    assign period_valid = period_valid_reg;
    assign locked       = locked_reg;
    assign err          = err_reg;
    assign err_count    = err_count_reg;
    assign stalled      = stalled_reg;

endmodule

// File: tb/tb_toggle_monitor.sv
// tb_toggle_monitor
// Directed stimulus for toggle_monitor. Each toggle that should produce a
// measurement pushes its hand-computed expected outputs into a queue; a
// separate monitor pops and compares whenever period_valid or err is seen.
module tb_toggle_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sig_in = 1'b0;
    logic [15:0] half_period;
    logic        period_valid;
    logic        locked;
    logic        err;
    logic [7:0]  err_count;
    logic        stalled;

    toggle_monitor #(
        .CNT_W   (16),
        .EXP_HALF(10),
        .TOL     (1),
        .LOCK_CNT(4),
        .TIMEOUT (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sig_in      (sig_in),
        .half_period (half_period),
        .period_valid(period_valid),
        .locked      (locked),
        .err         (err),
        .err_count   (err_count),
        .stalled     (stalled)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit pv;
        int hp;
        bit er;
        bit lk;
        bit st;
        int ec;
        int dt;   // expected cycles since previous event, -1 = don't care
    } exp_t;

    exp_t q[$];
    exp_t x;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   last_ev = 0;

    always @(posedge clock) cyc++;

    // Monitor: one line per observed output event.
    always @(negedge clock) begin
        if (!reset && (period_valid || err)) begin
            checks++;
            if (q.size() == 0) begin
                $display("FAIL event: unexpected pv=%0b hp=%0d err=%0b locked=%0b stalled=%0b err_count=%0d, required no event",
                         period_valid, half_period, err, locked, stalled, err_count);
            end else begin
                x = q.pop_front();
                if (period_valid !== x.pv || half_period !== 16'(x.hp) || err !== x.er ||
                    locked !== x.lk || stalled !== x.st || err_count !== 8'(x.ec) ||
                    (x.dt >= 0 && (cyc - last_ev) != x.dt)) begin
                    $display("FAIL event: got pv=%0b hp=%0d err=%0b locked=%0b stalled=%0b err_count=%0d dt=%0d, required pv=%0b hp=%0d err=%0b locked=%0b stalled=%0b err_count=%0d dt=%0d",
                             period_valid, half_period, err, locked, stalled, err_count, cyc - last_ev,
                             x.pv, x.hp, x.er, x.lk, x.st, x.ec, x.dt);
                end else begin
                    passes++;
                    $display("event ok: pv=%0b hp=%0d err=%0b locked=%0b stalled=%0b err_count=%0d",
                             period_valid, half_period, err, locked, stalled, err_count);
                end
            end
            last_ev = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            passes++;
            $display("check ok: %s = %0d", name, act);
        end
    endtask

    // Wait gap clocks, then toggle; optionally queue the expected measurement.
    task automatic tog(input int gap, input bit meas, input int hp, input bit er,
                       input bit lk, input int ec);
        exp_t e;
        repeat (gap) @(posedge clock);
        #1 sig_in = ~sig_in;
        if (meas) begin
            e.pv = 1'b1; e.hp = hp; e.er = er; e.lk = lk; e.st = 1'b0; e.ec = ec; e.dt = -1;
            q.push_back(e);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " half_period"}, int'(half_period), 0);
        chk({tag, " period_valid"}, int'(period_valid), 0);
        chk({tag, " locked"}, int'(locked), 0);
        chk({tag, " err"}, int'(err), 0);
        chk({tag, " err_count"}, int'(err_count), 0);
        chk({tag, " stalled"}, int'(stalled), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t s;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_all_zero("reset");
        @(posedge clock);
        #1 reset = 1'b0;

        // 1: steady 10-cycle toggling, first edge unmeasured, lock on 4th
        tog(10, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) tog(10, 1, 10, 0, i == 4, 0);

        // 2: one 13-cycle half-period breaks lock, then relock
        tog(13, 1, 13, 1, 0, 1);
        for (int i = 1; i <= 4; i++) tog(10, 1, 10, 0, i == 4, 1);

        // 3: tolerance boundaries 9/11 accepted, 8 and 12 rejected
        tog(8, 1, 8, 1, 0, 2);
        for (int i = 1; i <= 4; i++) tog((i % 2) ? 9 : 11, 1, (i % 2) ? 9 : 11, 0, i == 4, 2);
        tog(8, 1, 8, 1, 0, 3);
        tog(12, 1, 12, 1, 0, 4);
        for (int i = 1; i <= 4; i++) tog(10, 1, 10, 0, i == 4, 4);

        // 4: stall exactly 32 cycles after last measurement
        s.pv = 1'b0; s.hp = 10; s.er = 1'b1; s.lk = 1'b0; s.st = 1'b1; s.ec = 5; s.dt = 32;
        q.push_back(s);
        repeat (45) @(posedge clock);
        @(negedge clock);
        chk("stall stalled", int'(stalled), 1);
        chk("stall locked", int'(locked), 0);
        tog(1, 0, 0, 0, 0, 0);
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("post-stall edge stalled", int'(stalled), 0);
        chk("post-stall edge locked", int'(locked), 0);
        tog(5, 1, 10, 0, 0, 5);
        for (int i = 2; i <= 4; i++) tog(10, 1, 10, 0, i == 4, 5);

        // 5: 300 short half-periods saturate err_count
        for (int k = 1; k <= 300; k++) tog(3, 1, 3, 1, 0, (5 + k > 255) ? 255 : 5 + k);
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("err_count saturated", int'(err_count), 255);
        tog(4, 1, 10, 0, 0, 255);
        for (int i = 2; i <= 4; i++) tog(10, 1, 10, 0, i == 4, 255);
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("relocked before reset", int'(locked), 1);

        // 6: reset mid half-period while locked
        @(posedge clock);
        #1 begin
            reset = 1'b1;
            sig_in = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        chk_all_zero("mid reset");
        @(posedge clock);
        #1 reset = 1'b0;
        tog(10, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) tog(10, 1, 10, 0, i == 4, 0);

        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("pending events", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
